// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
//   Free-running WIDTH-bit binary up-counter that drives a two-digit,
//   common-anode 7-segment display. The segments are active-low.
//   The count wraps to zero after its maximum value. The display shows the
//   count in decimal as tens/units. A leading-zero tens digit is blanked.
//
// Parameters
//   WIDTH   counter width in bits, 1..6 (the maximum count 63 fits in two digits)
//
// Ports
//   clk     system clock; the count advances on the rising edge
//   rst     asynchronous, active-low reset (0 = count forced to zero at once)
//   result  [13:7] tens digit segments a..g, [6:0] units digit segments a..g,
//           active-low, purely combinational from the count register
// -----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [13:0] result
);

    // ------------------------------------------------------------------
    // Count register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Binary to BCD by repeated compare/subtract.
    // The count is at most 63, so six subtractions of 10 are enough.
    // The loop unrolls into a short combinational chain.
    // ------------------------------------------------------------------
    logic [6:0] value_ext;
    logic [6:0] rem_next;
    logic [3:0] tens_next;
    logic [3:0] digit_next [2];

    assign value_ext = 7'(count_reg);

    always_comb begin
        rem_next  = value_ext;
        tens_next = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem_next >= 7'd10) begin
                rem_next  = rem_next - 7'd10;
                tens_next = tens_next + 4'd1;
            end
        end
    end

    // Digit index 0 = units, 1 = tens.
    assign digit_next[0] = rem_next[3:0];
    assign digit_next[1] = tens_next;

    // ------------------------------------------------------------------
    // 7-segment decode (bit6 = a ... bit0 = g, 0 = lit).
    // Codes 10..15 cannot occur, but they decode to blank anyway.
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [6:0] seg_next [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
        if (gi == 1) begin : g_tens
            // A leading zero on the tens position is blanked, not shown as "0".
            assign seg_next[gi] = (digit_next[gi] == 4'd0) ? 7'b1111111
                                                           : seg7(digit_next[gi]);
        end else begin : g_units
            assign seg_next[gi] = seg7(digit_next[gi]);
        end
    end

    assign result = {seg_next[1], seg_next[0]};

endmodule

// File: tb/tb_counter.sv
module tb_counter;

    logic clk;
    logic rst;
    logic [13:0] result2;
    logic [13:0] result4;
    logic [13:0] result6;

    int errors = 0;
    int checks = 0;
    int n      = 0;   // rising edges seen with rst=1 since the last reset

    counter #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .result(result2));
    counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .result(result4));
    counter #(.WIDTH(6)) dut6 (.clk(clk), .rst(rst), .result(result6));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so that the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: decimal digits taken straight from the display table.
    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] tbl [10];
        tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010;
        tbl[3] = 7'b0000110; tbl[4] = 7'b1001100; tbl[5] = 7'b0100100;
        tbl[6] = 7'b0100000; tbl[7] = 7'b0001111; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0000100;
        return tbl[d];
    endfunction

    function automatic logic [13:0] ref_result(input int edges, input int width);
        int v;
        int tens;
        int units;
        logic [6:0] hi;
        v     = edges % (1 << width);
        tens  = v / 10;
        units = v % 10;
        hi    = (tens == 0) ? 7'b1111111 : ref_seg(tens);
        return {hi, ref_seg(units)};
    endfunction

    task automatic check_one(input string tag, input int width,
                             input logic [13:0] obs);
        logic [13:0] exp;
        exp = ref_result(n, width);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s W=%0d edges=%0d observed=%b expected=%b",
                   tag, width, n, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_one(tag, 2, result2);
        check_one(tag, 4, result4);
        check_one(tag, 6, result6);
        $display("check %-12s edges=%0d rst=%b W2=%b W4=%b W6=%b",
                 tag, n, rst, result2, result4, result6);
    endtask

    // Called from the falling edge: advance one rising edge, sample on the next fall.
    task automatic edge_check(input string tag);
        @(posedge clk);
        if (rst) n++;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        #2;
        // Asynchronous reset with no clock edge in between.
        rst = 1'b0;
        #1;
        check_all("reset_async");
        // The count holds at zero across edges while reset is held.
        @(negedge clk);
        edge_check("reset_hold");
        // Release reset away from the rising edge.
        rst = 1'b1;

        // Edges 1..3, then the WIDTH=2 wrap on edge 4.
        edge_check("edge1");
        edge_check("edge2");
        edge_check("edge3");
        edge_check("wrap_w2");

        // Reset in the middle of a count: at count 2, drop rst between edges.
        n = 0;
        rst = 1'b0;
        #1;
        check_all("clr");
        @(negedge clk);
        rst = 1'b1;
        edge_check("pre1");
        edge_check("pre2");
        #2;
        rst = 1'b0;
        n = 0;
        #1;
        check_all("mid_reset");
        edge_check("mid_hold");
        rst = 1'b1;

        // A long run that covers 10, 15, 16 (W4 wrap), 63 and 64 (W6 wrap).
        for (int i = 1; i <= 64; i++) begin
            edge_check("run");
        end

        // Random runs with randomly timed asynchronous resets.
        for (int it = 0; it < 25; it++) begin
            int len;
            len = $urandom_range(1, 70);
            for (int k = 0; k < len; k++) begin
                edge_check("rand_run");
            end
            if ($urandom_range(0, 1) == 1) begin
                #($urandom_range(1, 3));
                rst = 1'b0;
                n = 0;
                #1;
                check_all("rand_rst");
                @(negedge clk);
                check_all("rand_hold");
                rst = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
